systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Host-side counterpart to the systolic array driver; sits on the far end of its ready/valid input stream and its valid/yumi result stream.
- Holds operand matrices A (H x K) and B (K x W), loaded through a write port.
- On start, serialises the operands into the driver, waits a programmable drain time, then pulses flush.
- Collects the H*W results into a result buffer that can be read by index, then signals done.

Parameters:
width_p, 32, element and result width in bits
array_width_p, 2, W: columns of B and C
array_height_p, 2, H: rows of A and C
inner_dim_p, 2, K: columns of A, rows of B (K >= 1)
drain_cycles_p, 8, enabled cycles to wait between the last accepted element and the flush pulse (>= 1)

Ports:
clk_i  in  1  clock, all state updates on rising edge
reset_i  in  1  asynchronous, active-high reset
en_i  in  1  global enable; when low, all state (FSM, counters, buffers) holds
ld_v_i  in  1  operand write strobe; honoured only in IDLE
ld_sel_i  in  1  0 = write A, 1 = write B
ld_addr_i  in  $clog2(max(H*K,K*W))  row-major index: A[r][k] = r*K+k, B[k][c] = k*W+c
ld_data_i  in  width_p  operand value
start_i  in  1  begin a transfer; honoured only in IDLE
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse after the last result is captured
valid_o  out  1  stream element valid toward the array driver
ready_i  in  1  array driver ready
data_o  out  width_p  stream element
flush_o  out  1  one-cycle flush request to the array driver
valid_i  in  1  result valid from the array driver
yumi_o  out  1  result consumed
data_i  in  width_p  result value
rd_addr_i  in  $clog2(H*W)  result read index, row-major: C[r][c] = r*W+c
rd_data_o  out  width_p  combinational read of result[rd_addr_i]

Behaviour:
- Reset state: FSM = IDLE. All counters = 0. A, B and result buffers = 0. valid_o, flush_o, yumi_o, done_o, busy_o = 0. data_o = 0.
- All transitions below require en_i = 1; with en_i = 0 all outputs hold their registered values.
- States: IDLE, SEND, DRAIN, FLUSH, COLLECT, DONE.
- IDLE:
  - ld_v_i writes the selected buffer.
  - Out-of-range ld_addr_i is ignored.
  - start_i -> SEND with elem counter = 0. If ld_v_i and start_i are both high, the write completes first and the transfer uses the new value.
- SEND stream order, for step k = 0..K-1:
  - first A[0][k] .. A[H-1][k],
  - then B[k][0] .. B[k][W-1].
  - Total N = K*(H+W) elements.
- SEND handshake:
  - valid_o = 1 and data_o = the current element, registered.
  - On valid_o & ready_i the element is accepted and the counter advances; the next element appears the following cycle. No bubble is required, so one element can be accepted per cycle.
  - valid_o never drops and data_o never changes while ready_i is low.
  - When element N-1 is accepted -> DRAIN, with valid_o = 0 the next cycle.
- DRAIN: count drain_cycles_p enabled cycles, then -> FLUSH.
- FLUSH: flush_o = 1 for exactly one cycle; result index = 0; -> COLLECT.
- COLLECT:
  - yumi_o = valid_i (combinational, this state only).
  - On each valid_i, write data_i to result[index] and increment index.
  - When index H*W-1 is captured -> DONE.
  - valid_i in any other state is never yumi'd.
- DONE: done_o = 1 for one cycle -> IDLE.
- busy_o = (state != IDLE).
- start_i outside IDLE is ignored. ld_v_i outside IDLE is ignored (operands are stable during a transfer).
- Result buffer keeps its contents until overwritten by the next COLLECT or by reset.
- Asynchronous reset mid-operation: immediate return to reset state; any partial stream is abandoned.
- Counters use widths of $clog2 of their terminal count + 1 and never wrap within a transfer.

Test Plan:
- 2x2, K=2. Load A = [[1,2],[3,4]], B = [[5,6],[7,8]], start, ready_i tied 1 -> data_o sequence is 1,3,5,6,2,4,7,8 on 8 consecutive cycles; DRAIN lasts 8 cycles; single flush_o pulse.
- Same load, ready_i toggled 1,0,0,1,... -> same 8-element order; valid_o and data_o stay stable across every stall; no element is dropped or duplicated.
- Return results 19,22,43,50 with valid_i gaps of 0-3 cycles -> yumi_o high only when valid_i is high; done_o pulses once; rd_addr 0..3 reads 19,22,43,50.
- start_i and ld_v_i asserted during SEND -> both ignored; stream and A/B contents unchanged.
- en_i low for 5 cycles mid-SEND -> counter, FSM and outputs frozen; stream resumes exactly where it stopped.
- reset_i pulsed asynchronously mid-COLLECT -> busy_o = 0, valid_o = 0, yumi_o = 0, all buffers read 0 without waiting for a clock edge; a new start after reloading behaves as the first scenario.

Source files
------------

// File: rtl/systolic_feeder.sv
// Host-side feeder for a systolic array driver: holds A/B operands, streams them
// column-interleaved into the driver, flushes after a drain delay and collects H*W results.
module systolic_feeder #(
    parameter int width_p        = 32,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2,
    parameter int inner_dim_p    = 2,
    parameter int drain_cycles_p = 8,
    localparam int H      = array_height_p,
    localparam int W      = array_width_p,
    localparam int K      = inner_dim_p,
    localparam int NA     = H * K,
    localparam int NB     = K * W,
    localparam int NC     = H * W,
    localparam int LD_MAX = (NA > NB) ? NA : NB,
    localparam int LD_W   = (LD_MAX > 1) ? $clog2(LD_MAX) : 1,
    localparam int RD_W   = (NC > 1) ? $clog2(NC) : 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               ld_v_i,
    input  logic               ld_sel_i,
    input  logic [LD_W-1:0]    ld_addr_i,
    input  logic [width_p-1:0] ld_data_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [width_p-1:0] data_o,
    output logic               flush_o,
    input  logic               valid_i,
    output logic               yumi_o,
    input  logic [width_p-1:0] data_i,
    input  logic [RD_W-1:0]    rd_addr_i,
    output logic [width_p-1:0] rd_data_o
);
    localparam int AI_W = (NA > 1) ? $clog2(NA) : 1;
    localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int KC_W = $clog2(K + 1);
    localparam int JC_W = $clog2(H + W + 1);
    localparam int DC_W = $clog2(drain_cycles_p + 1);
    localparam int IC_W = $clog2(NC + 1);

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_DRAIN, S_FLUSH, S_COLLECT, S_DONE} state_e;

    state_e             state_q;
    logic [KC_W-1:0]    k_q, k_d;
    logic [JC_W-1:0]    j_q, j_d;
    logic [DC_W-1:0]    drn_q;
    logic [IC_W-1:0]    idx_q;
    logic               valid_q, flush_q, done_q;
    logic [width_p-1:0] data_q, elem;
    logic [width_p-1:0] a_q [NA];
    logic [width_p-1:0] a_d [NA];
    logic [width_p-1:0] b_q [NB];
    logic [width_p-1:0] b_d [NB];
    logic [width_p-1:0] c_q [NC];
    int                 ai, bi;
    logic               last_elem;

    // Operand writes are resolved combinationally so a start in the same cycle sees them.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (en_i && state_q == S_IDLE && ld_v_i) begin
            if (!ld_sel_i) begin
                if (int'(ld_addr_i) < NA) a_d[ld_addr_i[AI_W-1:0]] = ld_data_i;
            end else begin
                if (int'(ld_addr_i) < NB) b_d[ld_addr_i[BI_W-1:0]] = ld_data_i;
            end
        end
    end

    // Position of the element to present next: j walks H rows of A then W columns of B.
    always_comb begin
        if (state_q == S_IDLE) begin
            k_d = '0;
            j_d = '0;
        end else if (int'(j_q) == H + W - 1) begin
            k_d = k_q + 1'b1;
            j_d = '0;
        end else begin
            k_d = k_q;
            j_d = j_q + 1'b1;
        end
        ai = int'(j_d) * K + int'(k_d);
        bi = int'(k_d) * W + int'(j_d) - H;
        if (int'(k_d) >= K)    elem = '0;
        else if (int'(j_d) < H) elem = a_d[ai[AI_W-1:0]];
        else                    elem = b_d[bi[BI_W-1:0]];
        last_elem = (int'(k_q) == K - 1) && (int'(j_q) == H + W - 1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            j_q     <= '0;
            drn_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            for (int i = 0; i < NA; i++) a_q[i] <= '0;
            for (int i = 0; i < NB; i++) b_q[i] <= '0;
            for (int i = 0; i < NC; i++) c_q[i] <= '0;
        end else if (en_i) begin
            a_q     <= a_d;
            b_q     <= b_d;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: if (start_i) begin
                    state_q <= S_SEND;
                    k_q     <= '0;
                    j_q     <= '0;
                    valid_q <= 1'b1;
                    data_q  <= elem;
                end
                S_SEND: if (ready_i) begin
                    if (last_elem) begin
                        state_q <= S_DRAIN;
                        valid_q <= 1'b0;
                        drn_q   <= '0;
                    end else begin
                        k_q    <= k_d;
                        j_q    <= j_d;
                        data_q <= elem;
                    end
                end
                S_DRAIN: begin
                    if (int'(drn_q) == drain_cycles_p - 1) begin
                        state_q <= S_FLUSH;
                        flush_q <= 1'b1;
                    end else begin
                        drn_q <= drn_q + 1'b1;
                    end
                end
                S_FLUSH: begin
                    idx_q   <= '0;
                    state_q <= S_COLLECT;
                end
                S_COLLECT: if (valid_i) begin
                    c_q[idx_q[RD_W-1:0]] <= data_i;
                    idx_q                <= idx_q + 1'b1;
                    if (int'(idx_q) == NC - 1) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = done_q;
    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign flush_o   = flush_q;
    assign yumi_o    = en_i && valid_i && (state_q == S_COLLECT);
    assign rd_data_o = (int'(rd_addr_i) < NC) ? c_q[rd_addr_i] : '0;
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: expected stream queued at start, checked by a monitor.
module tb_systolic_feeder;
    localparam int WD = 32, H = 2, W = 2, K = 2, D = 8;
    localparam int N = K * (H + W), NC = H * W;

    logic          clk = 1'b0, rst, en_i, ld_v_i, ld_sel_i, start_i;
    logic [1:0]    ld_addr_i, rd_addr_i;
    logic [WD-1:0] ld_data_i, data_o, data_i, rd_data_o;
    logic          busy_o, done_o, valid_o, ready_i, flush_o, valid_i, yumi_o;

    systolic_feeder #(.width_p(WD), .array_width_p(W), .array_height_p(H),
                      .inner_dim_p(K), .drain_cycles_p(D)) dut (
        .clk_i(clk), .reset_i(rst), .en_i(en_i), .ld_v_i(ld_v_i), .ld_sel_i(ld_sel_i),
        .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i), .start_i(start_i), .busy_o(busy_o),
        .done_o(done_o), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .flush_o(flush_o), .valid_i(valid_i), .yumi_o(yumi_o), .data_i(data_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [WD-1:0] exp_q[$];
    logic [WD-1:0] Am[H*K], Bm[K*W], Cm[NC];
    int cyc = 0, last_acc = 0, first_acc = 0, acc_n = 0, flush_n = 0, done_n = 0, yumi_n = 0;
    bit pstall = 0;
    logic [WD-1:0] pdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Monitor: stream scoreboard, stall stability, drain length, yumi legality.
    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            if (pstall) begin
                check("stall_valid", valid_o, 1);
                check("stall_data", data_o, pdata);
            end
            pstall = valid_o && !(ready_i && en_i);
            pdata  = data_o;
            if (valid_o && ready_i && en_i) begin
                if (exp_q.size() == 0) check("extra_elem", exp_q.size(), 1);
                else check("stream", data_o, exp_q.pop_front());
                if (acc_n == 0) first_acc = cyc;
                acc_n++;
                last_acc = cyc;
            end
            if (flush_o && en_i) begin
                flush_n++;
                check("drain_gap", cyc - last_acc, D + 1);
            end
            if (yumi_o) begin
                check("yumi_needs_valid", valid_i, 1);
                yumi_n++;
            end
            if (done_o && en_i) done_n++;
        end else pstall = 0;
    end

    task automatic reset_check();
        check("rst_busy", busy_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_yumi", yumi_o, 0);
        check("rst_done", done_o, 0);
        check("rst_flush", flush_o, 0);
        check("rst_data", data_o, 0);
        for (int i = 0; i < NC; i++) begin
            rd_addr_i = 2'(i); #1;
            check("rst_rd", rd_data_o, 0);
        end
    endtask

    task automatic model();
        exp_q.delete();
        for (int k = 0; k < K; k++) begin
            for (int r = 0; r < H; r++) exp_q.push_back(Am[r*K+k]);
            for (int c = 0; c < W; c++) exp_q.push_back(Bm[k*W+c]);
        end
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                Cm[r*W+c] = '0;
                for (int k = 0; k < K; k++) Cm[r*W+c] += Am[r*K+k] * Bm[k*W+c];
            end
    endtask

    // A[0] is first written with a stale value; the correct one lands in the start cycle.
    task automatic load();
        for (int i = 0; i < H*K; i++) begin
            ld_v_i = 1; ld_sel_i = 0; ld_addr_i = 2'(i);
            ld_data_i = (i == 0) ? ~Am[0] : Am[i]; tick();
        end
        for (int i = 0; i < K*W; i++) begin
            ld_v_i = 1; ld_sel_i = 1; ld_addr_i = 2'(i); ld_data_i = Bm[i]; tick();
        end
        ld_v_i = 0;
    endtask

    // mode: 0 ready=1, 1 ready pattern 1,0,0,1, 2 random ready
    task automatic run(input int mode, input bit freeze, input bit interfere, input int stop_after);
        bit seen = 0, got;
        int t = 0;
        bit pat [4] = '{1, 0, 0, 1};
        model();
        load();
        acc_n = 0; flush_n = 0; done_n = 0; yumi_n = 0;
        ld_v_i = 1; ld_sel_i = 0; ld_addr_i = 0; ld_data_i = Am[0]; start_i = 1;
        tick();
        ld_v_i = 0; start_i = 0;
        while (!seen && t < 400) begin
            ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? pat[t%4] : 1'($urandom);
            en_i    = !(freeze && t >= 4 && t < 9);
            if (interfere && t == 3) begin
                start_i = 1; ld_v_i = 1; ld_sel_i = 1; ld_addr_i = 3; ld_data_i = 32'hDEAD;
            end else begin
                start_i = 0; ld_v_i = 0;
            end
            @(negedge clk);
            if (flush_o && en_i) seen = 1;
            tick();
            t++;
        end
        start_i = 0; ld_v_i = 0; en_i = 1; ready_i = 0;
        check("flush_seen", seen, 1);
        check("stream_left", exp_q.size(), 0);
        check("accepts", acc_n, N);
        check("flush_pulses", flush_n, 1);
        if (mode == 0) check("back_to_back", last_acc - first_acc, N - 1);
        for (int i = 0; i < NC; i++) begin
            if (i == stop_after) return;
            valid_i = 0;
            repeat ($urandom_range(0, 3)) tick();
            valid_i = 1; data_i = Cm[i]; got = 0;
            for (int w = 0; w < 50 && !got; w++) begin
                @(negedge clk);
                if (yumi_o) got = 1;
                tick();
            end
            check("yumi_seen", got, 1);
        end
        valid_i = 0;
        for (int w = 0; w < 20 && done_n == 0; w++) tick();
        repeat (3) tick();
        check("done_pulses", done_n, 1);
        check("yumi_count", yumi_n, NC);
        check("idle_after", busy_o, 0);
        for (int i = 0; i < NC; i++) begin
            rd_addr_i = 2'(i); #1;
            check("rd_data", rd_data_o, Cm[i]);
        end
    endtask

    initial begin
        rst = 1; en_i = 1; ld_v_i = 0; ld_sel_i = 0; ld_addr_i = 0; ld_data_i = 0;
        start_i = 0; ready_i = 0; valid_i = 0; data_i = 0; rd_addr_i = 0;
        #12 reset_check();
        #3 rst = 0;
        tick();

        Am = '{1, 2, 3, 4}; Bm = '{5, 6, 7, 8};
        run(0, 0, 0, NC);
        run(1, 0, 1, NC);
        for (int n = 0; n < 3; n++) begin
            foreach (Am[i]) Am[i] = $urandom;
            foreach (Bm[i]) Bm[i] = $urandom;
            run(2, n == 0, n == 1, NC);
        end

        Am = '{1, 2, 3, 4}; Bm = '{5, 6, 7, 8};
        run(0, 0, 0, 2);
        valid_i = 1; data_i = 32'h1234;
        @(posedge clk); #3 rst = 1;
        #1 reset_check();
        tick();
        rst = 0; valid_i = 0; exp_q.delete();
        tick();
        run(0, 0, 0, NC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
